// File: rtl/brick_pkg.sv
// ============================================================================
// Module   : brick_pkg
// Brief    : Shared state encoding and width helpers for the brick field.
// Revision : 1.0
// ============================================================================
`default_nettype none

package brick_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_CLEARED = 2'd3
  } state_e;

  localparam int C_DEF_ROWS         = 4;
  localparam int C_DEF_COLS         = 8;
  localparam int C_DEF_HP_W         = 2;
  localparam int C_DEF_BRICK_W_LOG2 = 6;
  localparam int C_DEF_BRICK_H_LOG2 = 4;
  localparam int C_DEF_TOP          = 40;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/brick_pixel_map.sv
// ============================================================================
// Module   : brick_pixel_map
// Brief    : Pixel (x,y) to brick {in_region, row, col, mortar} decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module brick_pixel_map
  import brick_pkg::*;
#(
  parameter int ROWS         = C_DEF_ROWS,
  parameter int COLS         = C_DEF_COLS,
  parameter int BRICK_W_LOG2 = C_DEF_BRICK_W_LOG2,
  parameter int BRICK_H_LOG2 = C_DEF_BRICK_H_LOG2,
  parameter int TOP          = C_DEF_TOP
) (
  input  logic [9:0]                x_i,
  input  logic [9:0]                y_i,
  output logic                      in_region_o,
  output logic [idx_w(ROWS)-1:0]    row_o,
  output logic [idx_w(COLS)-1:0]    col_o,
  output logic                      mortar_o
);

  localparam int         C_ROW_W   = idx_w(ROWS);
  localparam int         C_COL_W   = idx_w(COLS);
  localparam logic [10:0] C_FIELD_W = 11'(COLS << BRICK_W_LOG2);
  localparam logic [10:0] C_FIELD_H = 11'(ROWS << BRICK_H_LOG2);
  localparam logic [10:0] C_TOP11   = 11'(TOP);
  localparam logic [9:0]  C_TOP10   = 10'(TOP);

  logic [9:0] w_dy;
  logic       w_in_x;
  logic       w_in_y;

  assign w_dy   = y_i - C_TOP10;
  assign w_in_x = ({1'b0, x_i} < C_FIELD_W);
  // Checking y >= TOP first keeps the wrapped dy of rows above the field out.
  assign w_in_y = ({1'b0, y_i} >= C_TOP11) && ({1'b0, w_dy} < C_FIELD_H);

  assign in_region_o = w_in_x && w_in_y;
  assign col_o       = x_i[BRICK_W_LOG2 +: C_COL_W];
  assign row_o       = w_dy[BRICK_H_LOG2 +: C_ROW_W];
  assign mortar_o    = (&x_i[BRICK_W_LOG2-1:0]) | (&w_dy[BRICK_H_LOG2-1:0]);

endmodule

`default_nettype wire

// File: rtl/brick_field.sv
// ============================================================================
// Module   : brick_field
// Brief    : ROWS x COLS multi-hit brick field with hit handshake, live count
//            and registered per-pixel query. Optional macro ROW_HP_EN loads
//            row-graded hit points instead of INIT_HP.
// Revision : 1.0
// ============================================================================
`default_nettype none

module brick_field
  import brick_pkg::*;
#(
  parameter int ROWS         = C_DEF_ROWS,
  parameter int COLS         = C_DEF_COLS,
  parameter int HP_W         = C_DEF_HP_W,
  parameter int INIT_HP      = 1,
  parameter int BRICK_W_LOG2 = C_DEF_BRICK_W_LOG2,
  parameter int BRICK_H_LOG2 = C_DEF_BRICK_H_LOG2,
  parameter int TOP          = C_DEF_TOP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          level_load,
  input  logic                          hit_valid,
  input  logic [idx_w(ROWS)-1:0]        hit_row,
  input  logic [idx_w(COLS)-1:0]        hit_col,
  output logic                          hit_ready,
  output logic                          hit_destroyed,
  input  logic [9:0]                    x_pos,
  input  logic [9:0]                    y_pos,
  output logic                          pix_brick,
  output logic [HP_W-1:0]               pix_hp,
  output logic [cnt_w(ROWS*COLS)-1:0]   bricks_left,
  output logic                          level_clear,
  output logic                          busy
);

  localparam int C_NUM   = ROWS * COLS;
  localparam int C_ROW_W = idx_w(ROWS);
  localparam int C_COL_W = idx_w(COLS);
  localparam int C_IDX_W = idx_w(C_NUM);
  localparam int C_CNT_W = cnt_w(C_NUM);
  localparam int C_HP_MAX = (1 << HP_W) - 1;

  state_e               state_q, state_d;
  logic [C_ROW_W-1:0]   load_row_q, load_row_d;
  logic [C_COL_W-1:0]   load_col_q, load_col_d;
  logic [C_CNT_W-1:0]   left_q, left_d;
  logic                 destroyed_q, destroyed_d;
  logic                 clear_q, clear_d;
  logic                 pix_brick_q;
  logic [HP_W-1:0]      pix_hp_q;
  logic [HP_W-1:0]      hp_q [C_NUM];

  logic                 w_hp_we;
  logic [C_IDX_W-1:0]   w_hp_widx;
  logic [HP_W-1:0]      w_hp_wdata;

  logic                 w_hit_in_range;
  logic [C_IDX_W-1:0]   w_hit_idx;
  logic [HP_W-1:0]      w_hit_hp;
  logic                 w_hit_live;
  logic [C_IDX_W-1:0]   w_load_idx;
  logic [HP_W-1:0]      w_load_hp;

  logic                 w_pix_in_region;
  logic [C_ROW_W-1:0]   w_pix_row;
  logic [C_COL_W-1:0]   w_pix_col;
  logic                 w_pix_mortar;
  logic [C_IDX_W-1:0]   w_pix_idx;
  logic [HP_W-1:0]      w_pix_hp;
  logic                 w_pix_on;

  // Hit decode; out-of-range requests are steered to index 0 and masked.
  assign w_hit_in_range = (32'(hit_row) < 32'(ROWS)) && (32'(hit_col) < 32'(COLS));
  assign w_hit_idx      = w_hit_in_range
                          ? C_IDX_W'(32'(hit_row) * 32'(COLS) + 32'(hit_col))
                          : '0;
  assign w_hit_hp       = hp_q[w_hit_idx];
  assign w_hit_live     = w_hit_in_range && (w_hit_hp != '0);

  assign w_load_idx = C_IDX_W'(32'(load_row_q) * 32'(COLS) + 32'(load_col_q));

`ifdef ROW_HP_EN
  logic [31:0] w_rows_left;
  assign w_rows_left = 32'(ROWS) - 32'(load_row_q);
  assign w_load_hp   = (w_rows_left > 32'(C_HP_MAX)) ? HP_W'(C_HP_MAX)
                                                     : w_rows_left[HP_W-1:0];
`else
  assign w_load_hp = HP_W'(INIT_HP);
`endif

  always_comb begin
    state_d     = state_q;
    load_row_d  = load_row_q;
    load_col_d  = load_col_q;
    left_d      = left_q;
    destroyed_d = 1'b0;
    clear_d     = 1'b0;
    w_hp_we     = 1'b0;
    w_hp_widx   = w_hit_idx;
    w_hp_wdata  = w_hit_hp - HP_W'(1);

    case (state_q)
      ST_RESET: begin
        state_d    = ST_LOAD;
        load_row_d = '0;
        load_col_d = '0;
        left_d     = '0;
      end
      ST_LOAD: begin
        w_hp_we    = 1'b1;
        w_hp_widx  = w_load_idx;
        w_hp_wdata = w_load_hp;
        left_d     = left_q + C_CNT_W'(1);
        if (load_col_q == C_COL_W'(COLS - 1)) begin
          load_col_d = '0;
          if (load_row_q == C_ROW_W'(ROWS - 1)) begin
            load_row_d = '0;
            state_d    = ST_RUN;
          end else begin
            load_row_d = load_row_q + C_ROW_W'(1);
          end
        end else begin
          load_col_d = load_col_q + C_COL_W'(1);
        end
      end
      ST_RUN: begin
        // A reload request beats any hit presented in the same cycle.
        if (level_load) begin
          state_d    = ST_LOAD;
          load_row_d = '0;
          load_col_d = '0;
          left_d     = '0;
        end else if (hit_valid && w_hit_live) begin
          w_hp_we = 1'b1;
          if (w_hit_hp == HP_W'(1)) begin
            destroyed_d = 1'b1;
            left_d      = left_q - C_CNT_W'(1);
            if (left_q == C_CNT_W'(1)) begin
              clear_d = 1'b1;
              state_d = ST_CLEARED;
            end
          end
        end
      end
      ST_CLEARED: begin
        if (level_load) begin
          state_d    = ST_LOAD;
          load_row_d = '0;
          load_col_d = '0;
          left_d     = '0;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RESET;
      load_row_q  <= '0;
      load_col_q  <= '0;
      left_q      <= '0;
      destroyed_q <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_row_q  <= load_row_d;
      load_col_q  <= load_col_d;
      left_q      <= left_d;
      destroyed_q <= destroyed_d;
      clear_q     <= clear_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < C_NUM; i++) begin
        hp_q[i] <= '0;
      end
    end else if (w_hp_we) begin
      hp_q[w_hp_widx] <= w_hp_wdata;
    end
  end

  brick_pixel_map #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .BRICK_W_LOG2 (BRICK_W_LOG2),
    .BRICK_H_LOG2 (BRICK_H_LOG2),
    .TOP          (TOP)
  ) u_pixel_map (
    .x_i         (x_pos),
    .y_i         (y_pos),
    .in_region_o (w_pix_in_region),
    .row_o       (w_pix_row),
    .col_o       (w_pix_col),
    .mortar_o    (w_pix_mortar)
  );

  // The query sees HP as held in the array at the sampling edge, no bypass.
  assign w_pix_idx = w_pix_in_region
                     ? C_IDX_W'(32'(w_pix_row) * 32'(COLS) + 32'(w_pix_col))
                     : '0;
  assign w_pix_hp  = hp_q[w_pix_idx];
  assign w_pix_on  = w_pix_in_region && !w_pix_mortar && (w_pix_hp != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_brick_q <= 1'b0;
      pix_hp_q    <= '0;
    end else begin
      pix_brick_q <= w_pix_on;
      pix_hp_q    <= w_pix_on ? w_pix_hp : '0;
    end
  end

  assign hit_ready     = (state_q == ST_RUN);
  assign busy          = (state_q == ST_RESET) || (state_q == ST_LOAD);
  assign hit_destroyed = destroyed_q;
  assign level_clear   = clear_q;
  assign bricks_left   = left_q;
  assign pix_brick     = pix_brick_q;
  assign pix_hp        = pix_hp_q;

endmodule

`default_nettype wire
